// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared definitions for the ID/EX register and hazard control block:
// forwarding select codes, control-vector bit positions, halt FSM states,
// bubble constants and a register-match helper.
package id_ex_hazard_ctrl_pkg;

    // Branch-compare operand select codes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // WB vector {RegWrite, MemToReg}
    localparam int unsigned WB_REGWRITE = 1;

    // MEM vector {Branch[1], MemR, MemW, Branch[0]}
    localparam int unsigned MEM_BRANCH1 = 3;
    localparam int unsigned MEM_MEMR    = 2;
    localparam int unsigned MEM_BRANCH0 = 0;

    // EX vector {ALUSrc, RegDst, ALUOp[1:0]}
    localparam int unsigned EX_REGDST = 2;

    // Control values latched for an inserted bubble
    localparam logic [1:0] BUBBLE_WB  = 2'b00;
    localparam logic [3:0] BUBBLE_MEM = 4'b0000;
    localparam logic [3:0] BUBBLE_EX  = 4'b0000;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StDrain  = 2'b01,
        StHalted = 2'b10
    } halt_state_e;

    // True when a producer writing dest feeds source register src; $0 never matches
    function automatic logic reg_hit(input logic [4:0] dest, input logic [4:0] src);
        return (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/id_ex_hazard_ctrl_hazard_detect.sv
// Combinational hazard detection: load-use stall, branch-operand stall and
// branch-compare forwarding selects for decode.
// Optional feature: BRANCH_STALL_EN enables the branch-operand stall.
module id_ex_hazard_ctrl_hazard_detect
    import id_ex_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_branch,
    input  logic       i_ex_memr,
    input  logic       i_ex_regwrite,
    input  logic       i_ex_regdst,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_ex_rd,
    input  logic       i_mem_regwrite,
    input  logic       i_mem_memr,
    input  logic [4:0] i_mem_wrreg,
    input  logic       i_wb_we,
    input  logic [4:0] i_wb_wrreg,
    output logic       o_load_use,
    output logic       o_branch_stall,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    logic [4:0] w_ex_dest;
    logic       w_branch_hazard;

    // Load in EX whose destination is a source of the instruction in decode
    always_comb begin
        o_load_use = i_ex_memr && (reg_hit(i_ex_rt, i_id_rs) || reg_hit(i_ex_rt, i_id_rt));
    end

    // Branch in decode whose operands are not yet available to the compare
    always_comb begin
        w_ex_dest       = i_ex_regdst ? i_ex_rd : i_ex_rt;
        w_branch_hazard = i_id_branch &&
                          ((i_ex_regwrite &&
                            (reg_hit(w_ex_dest, i_id_rs) || reg_hit(w_ex_dest, i_id_rt))) ||
                           (i_mem_memr &&
                            (reg_hit(i_mem_wrreg, i_id_rs) || reg_hit(i_mem_wrreg, i_id_rt))));
    end

`ifdef BRANCH_STALL_EN
    assign o_branch_stall = w_branch_hazard;
`else
    // Without the feature, software schedules around branch-operand hazards
    logic w_unused_branch_hazard;
    assign w_unused_branch_hazard = w_branch_hazard;
    assign o_branch_stall         = 1'b0;
`endif

    // Forward select per operand; MEM result is younger so it wins over WB
    always_comb begin
        o_fwd_a = FWD_RF;
        if (i_mem_regwrite && reg_hit(i_mem_wrreg, i_id_rs)) begin
            o_fwd_a = FWD_MEM;
        end else if (i_wb_we && reg_hit(i_wb_wrreg, i_id_rs)) begin
            o_fwd_a = FWD_WB;
        end

        o_fwd_b = FWD_RF;
        if (i_mem_regwrite && reg_hit(i_mem_wrreg, i_id_rt)) begin
            o_fwd_b = FWD_MEM;
        end else if (i_wb_we && reg_hit(i_wb_wrreg, i_id_rt)) begin
            o_fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX pipeline register with hazard control and halt drain FSM.
// Latches decoded control/operands each cycle, inserts bubbles on load-use,
// undefined instructions and halt, flushes IF/ID on a taken branch.
// Optional feature: BRANCH_STALL_EN (branch-operand stall in hazard_detect).
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DW           = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    id_wb,
    input  logic [3:0]    id_mem,
    input  logic [3:0]    id_ex,
    input  logic [DW-1:0] id_a,
    input  logic [DW-1:0] id_b,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic          id_halt,
    input  logic          id_undef,
    input  logic          branch_taken,
    input  logic          mem_regwrite,
    input  logic [4:0]    mem_wrreg,
    input  logic          mem_memr,
    input  logic          wb_we,
    input  logic [4:0]    wb_wrreg,
    output logic [1:0]    ex_wb,
    output logic [3:0]    ex_mem,
    output logic [3:0]    ex_ex,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic          pipe_stall,
    output logic          if_id_flush,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          halted,
    output logic          undef_seen
);

    localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_CYCLES - 1);

    logic [1:0]    r_ex_wb;
    logic [3:0]    r_ex_mem;
    logic [3:0]    r_ex_ex;
    logic [DW-1:0] r_ex_a;
    logic [DW-1:0] r_ex_b;
    logic [DW-1:0] r_ex_imm;
    logic [4:0]    r_ex_rs;
    logic [4:0]    r_ex_rt;
    logic [4:0]    r_ex_rd;
    logic          r_undef_seen;

    halt_state_e   r_state;
    logic [CntW-1:0] r_cnt;
    logic          r_halted;

    logic          w_load_use;
    logic          w_branch_stall;
    logic          w_pipe_stall;
    logic          w_bubble;

    id_ex_hazard_ctrl_hazard_detect u_hazard_detect (
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_branch    (id_mem[MEM_BRANCH1] | id_mem[MEM_BRANCH0]),
        .i_ex_memr      (r_ex_mem[MEM_MEMR]),
        .i_ex_regwrite  (r_ex_wb[WB_REGWRITE]),
        .i_ex_regdst    (r_ex_ex[EX_REGDST]),
        .i_ex_rt        (r_ex_rt),
        .i_ex_rd        (r_ex_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_mem_memr     (mem_memr),
        .i_mem_wrreg    (mem_wrreg),
        .i_wb_we        (wb_we),
        .i_wb_wrreg     (wb_wrreg),
        .o_load_use     (w_load_use),
        .o_branch_stall (w_branch_stall),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b)
    );

    // Stall sources: data hazards in RUN, and the whole pipe once halt has issued
    always_comb begin
        w_pipe_stall = w_load_use || w_branch_stall || (r_state != StRun);
        // A stalled, undefined or halting instruction must not enter EX
        w_bubble     = w_pipe_stall || id_undef || id_halt;
    end

    assign pipe_stall  = w_pipe_stall;
    assign if_id_flush = branch_taken & ~w_pipe_stall;

    // ID/EX register: capture decode outputs or a bubble; sticky undefined flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_wb      <= BUBBLE_WB;
            r_ex_mem     <= BUBBLE_MEM;
            r_ex_ex      <= BUBBLE_EX;
            r_ex_a       <= '0;
            r_ex_b       <= '0;
            r_ex_imm     <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_rd      <= '0;
            r_undef_seen <= 1'b0;
        end else begin
            if (w_bubble) begin
                r_ex_wb  <= BUBBLE_WB;
                r_ex_mem <= BUBBLE_MEM;
                r_ex_ex  <= BUBBLE_EX;
                r_ex_a   <= '0;
                r_ex_b   <= '0;
                r_ex_imm <= '0;
                r_ex_rs  <= '0;
                r_ex_rt  <= '0;
                r_ex_rd  <= '0;
            end else begin
                r_ex_wb  <= id_wb;
                r_ex_mem <= id_mem;
                r_ex_ex  <= id_ex;
                r_ex_a   <= id_a;
                r_ex_b   <= id_b;
                r_ex_imm <= id_imm;
                r_ex_rs  <= id_rs;
                r_ex_rt  <= id_rt;
                r_ex_rd  <= id_rd;
            end
            if (id_undef && !w_pipe_stall) begin
                r_undef_seen <= 1'b1;
            end
        end
    end

    // Halt FSM: a halt held behind a stall waits; once issued, drain EX/MEM/WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StRun;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (id_halt && !w_pipe_stall) begin
                        r_state <= StDrain;
                        r_cnt   <= '0;
                    end
                end
                StDrain: begin
                    if (r_cnt == CntLast) begin
                        r_state  <= StHalted;
                        r_halted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StHalted: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= StRun;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign ex_wb      = r_ex_wb;
    assign ex_mem     = r_ex_mem;
    assign ex_ex      = r_ex_ex;
    assign ex_a       = r_ex_a;
    assign ex_b       = r_ex_b;
    assign ex_imm     = r_ex_imm;
    assign ex_rs      = r_ex_rs;
    assign ex_rt      = r_ex_rt;
    assign ex_rd      = r_ex_rd;
    assign halted     = r_halted;
    assign undef_seen = r_undef_seen;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl. A reference model predicts the
// combinational outputs and the next ID/EX contents for every driven cycle;
// predictions are queued at drive time and popped when the DUT is sampled.
module tb_id_ex_hazard_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    id_wb = '0;
    logic [3:0]    id_mem = '0;
    logic [3:0]    id_ex = '0;
    logic [DW-1:0] id_a = '0, id_b = '0, id_imm = '0;
    logic [4:0]    id_rs = '0, id_rt = '0, id_rd = '0;
    logic          id_halt = 1'b0, id_undef = 1'b0, branch_taken = 1'b0;
    logic          mem_regwrite = 1'b0, mem_memr = 1'b0, wb_we = 1'b0;
    logic [4:0]    mem_wrreg = '0, wb_wrreg = '0;
    logic [1:0]    ex_wb;
    logic [3:0]    ex_mem, ex_ex;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic          pipe_stall, if_id_flush, halted, undef_seen;
    logic [1:0]    fwd_a, fwd_b;

    always #5 clk = ~clk;

    id_ex_hazard_ctrl #(
        .DW           (DW),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_wb        (id_wb),
        .id_mem       (id_mem),
        .id_ex        (id_ex),
        .id_a         (id_a),
        .id_b         (id_b),
        .id_imm       (id_imm),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_halt      (id_halt),
        .id_undef     (id_undef),
        .branch_taken (branch_taken),
        .mem_regwrite (mem_regwrite),
        .mem_wrreg    (mem_wrreg),
        .mem_memr     (mem_memr),
        .wb_we        (wb_we),
        .wb_wrreg     (wb_wrreg),
        .ex_wb        (ex_wb),
        .ex_mem       (ex_mem),
        .ex_ex        (ex_ex),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_imm       (ex_imm),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .pipe_stall   (pipe_stall),
        .if_id_flush  (if_id_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .halted       (halted),
        .undef_seen   (undef_seen)
    );

    typedef struct packed {
        logic [1:0]  wb;
        logic [3:0]  mem;
        logic [3:0]  ex;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        halt;
        logic        undef;
        logic        br_taken;
        logic        mem_regwrite;
        logic [4:0]  mem_wrreg;
        logic        mem_memr;
        logic        wb_we;
        logic [4:0]  wb_wrreg;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_comb_t;

    typedef struct packed {
        logic [9:0]  ctrl;   // {wb, mem, ex}
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [14:0] regs;   // {rs, rt, rd}
        logic        halted;
        logic        undef;
    } exp_reg_t;

    exp_comb_t q_comb[$];
    exp_reg_t  q_reg[$];

    // Reference model state
    exp_reg_t m_ex;
    int       m_state;  // 0 run, 1 drain, 2 halted
    int       m_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] d, input logic [4:0] s);
        return (d != 5'd0) && (d == s);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input stim_t s);
        if (s.mem_regwrite && hit(s.mem_wrreg, src)) return 2'b10;
        if (s.wb_we && hit(s.wb_wrreg, src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s);
        id_wb        = s.wb;
        id_mem       = s.mem;
        id_ex        = s.ex;
        id_a         = s.a;
        id_b         = s.b;
        id_imm       = s.imm;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_rd        = s.rd;
        id_halt      = s.halt;
        id_undef     = s.undef;
        branch_taken = s.br_taken;
        mem_regwrite = s.mem_regwrite;
        mem_wrreg    = s.mem_wrreg;
        mem_memr     = s.mem_memr;
        wb_we        = s.wb_we;
        wb_wrreg     = s.wb_wrreg;
    endtask

    // Predict this cycle's outputs from the model state, then advance the model
    task automatic predict(input stim_t s);
        exp_comb_t c;
        exp_reg_t  r;
        logic      lu, bs, stall, bubble;
        logic [4:0] ex_rt_m, ex_rd_m, dest;
        ex_rt_m = m_ex.regs[9:5];
        ex_rd_m = m_ex.regs[4:0];
        lu = m_ex.ctrl[6] && (hit(ex_rt_m, s.rs) || hit(ex_rt_m, s.rt));
        dest = m_ex.ctrl[2] ? ex_rd_m : ex_rt_m;
        bs = 1'b0;
`ifdef BRANCH_STALL_EN
        bs = (s.mem[3] | s.mem[0]) &&
             ((m_ex.ctrl[9] && (hit(dest, s.rs) || hit(dest, s.rt))) ||
              (s.mem_memr && (hit(s.mem_wrreg, s.rs) || hit(s.mem_wrreg, s.rt))));
`endif
        stall   = lu || bs || (m_state != 0);
        c.stall = stall;
        c.flush = s.br_taken && !stall;
        c.fa    = fwd_sel(s.rs, s);
        c.fb    = fwd_sel(s.rt, s);
        q_comb.push_back(c);

        bubble = stall || s.undef || s.halt;
        r = m_ex;
        if (bubble) begin
            r.ctrl = '0; r.a = '0; r.b = '0; r.imm = '0; r.regs = '0;
        end else begin
            r.ctrl = {s.wb, s.mem, s.ex};
            r.a    = s.a;
            r.b    = s.b;
            r.imm  = s.imm;
            r.regs = {s.rs, s.rt, s.rd};
        end
        if (s.undef && !stall) r.undef = 1'b1;
        case (m_state)
            0: if (s.halt && !stall) begin m_state = 1; m_cnt = 0; end
            1: begin
                if (m_cnt == int'(DRAIN) - 1) begin m_state = 2; r.halted = 1'b1; end
                else m_cnt++;
            end
            default: ;
        endcase
        m_ex = r;
        q_reg.push_back(r);
    endtask

    task automatic step(input stim_t s);
        exp_comb_t c;
        exp_reg_t  r;
        @(negedge clk);
        apply(s);
        predict(s);
        #1;
        c = q_comb.pop_front();
        check_eq("pipe_stall", 64'(pipe_stall), 64'(c.stall));
        check_eq("if_id_flush", 64'(if_id_flush), 64'(c.flush));
        check_eq("fwd_a", 64'(fwd_a), 64'(c.fa));
        check_eq("fwd_b", 64'(fwd_b), 64'(c.fb));
        @(posedge clk);
        #1;
        r = q_reg.pop_front();
        check_eq("ex_ctrl", 64'({ex_wb, ex_mem, ex_ex}), 64'(r.ctrl));
        check_eq("ex_a", 64'(ex_a), 64'(r.a));
        check_eq("ex_b", 64'(ex_b), 64'(r.b));
        check_eq("ex_imm", 64'(ex_imm), 64'(r.imm));
        check_eq("ex_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'(r.regs));
        check_eq("status", 64'({halted, undef_seen}), 64'({r.halted, r.undef}));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        @(negedge clk);
        apply('0);
        rst = 1'b1;
        #1;
        check_eq("rst_ctrl", 64'({ex_wb, ex_mem, ex_ex}), 64'd0);
        check_eq("rst_data", 64'({ex_a, ex_b, ex_imm}), 64'd0);
        check_eq("rst_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'd0);
        check_eq("rst_stall_flush", 64'({pipe_stall, if_id_flush}), 64'd0);
        check_eq("rst_status", 64'({halted, undef_seen}), 64'd0);
        m_ex    = '0;
        m_state = 0;
        m_cnt   = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        stim_t s;
        m_ex = '0; m_state = 0; m_cnt = 0;
        do_reset();

        // Plain pass-through
        s = '0; s.wb = 2'b10; s.ex = 4'b0110; s.a = 32'h1234_5678; s.b = 32'h9abc_def0;
        s.imm = 32'hffff_fff0; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd3;
        step(s);

        // lw $5 in EX, consumer reads $5: one stall cycle then passes
        s = '0; s.wb = 2'b11; s.mem = 4'b0100; s.ex = 4'b1000; s.rs = 5'd1; s.rt = 5'd5;
        step(s);
        s = '0; s.wb = 2'b10; s.rs = 5'd5; s.rt = 5'd6; s.rd = 5'd7; s.a = 32'h55;
        step(s);
        check_eq("lu_bubble_wb", 64'(ex_wb), 64'd0);
        step(s);
        check_eq("lu_pass_wb", 64'(ex_wb), 64'd2);

        // Forwarding priority and $0
        s = '0; s.mem_regwrite = 1'b1; s.mem_wrreg = 5'd3; s.wb_we = 1'b1; s.wb_wrreg = 5'd3;
        s.rs = 5'd3; s.rt = 5'd3;
        step(s);
        s.mem_regwrite = 1'b0;
        step(s);
        s.rs = 5'd0; s.rt = 5'd0; s.wb_wrreg = 5'd0;
        step(s);

        // Taken branch without hazard flushes
        s = '0; s.br_taken = 1'b1; s.mem = 4'b0001; s.rs = 5'd2; s.rt = 5'd1;
        step(s);

        // Taken branch under load-use: stall wins, then flush
        s = '0; s.wb = 2'b11; s.mem = 4'b0100; s.rt = 5'd9;
        step(s);
        s = '0; s.br_taken = 1'b1; s.mem = 4'b1000; s.rs = 5'd9;
        step(s);
        step(s);

        // EX add writes $4 (RegDst, rd=4) followed by branch on $4
        s = '0; s.wb = 2'b10; s.ex = 4'b0110; s.rs = 5'd1; s.rt = 5'd8; s.rd = 5'd4;
        step(s);
        s = '0; s.mem = 4'b0001; s.rs = 5'd4; s.br_taken = 1'b1;
        step(s);
        step(s);
        // Load in MEM feeding a branch operand
        s = '0; s.mem = 4'b1000; s.rt = 5'd6; s.mem_memr = 1'b1; s.mem_wrreg = 5'd6;
        step(s);

        // Undefined instruction becomes a bubble, flag is sticky
        s = '0; s.undef = 1'b1; s.wb = 2'b11; s.mem = 4'b0110; s.ex = 4'hf; s.a = 32'hdead;
        step(s);
        s = '0;
        step(s);
        step(s);
        check_eq("undef_sticky", 64'(undef_seen), 64'd1);

        // Random traffic, no halt/undef
        for (int i = 0; i < 30; i++) begin
            s = '0;
            s.wb = 2'($urandom_range(0, 3));
            s.mem = 4'($urandom_range(0, 15));
            s.ex = 4'($urandom_range(0, 15));
            s.a = $urandom; s.b = $urandom; s.imm = $urandom;
            s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
            s.rd = 5'($urandom_range(0, 7));
            s.br_taken = 1'($urandom_range(0, 1));
            s.mem_regwrite = 1'($urandom_range(0, 1));
            s.mem_wrreg = 5'($urandom_range(0, 7));
            s.mem_memr = 1'($urandom_range(0, 1));
            s.wb_we = 1'($urandom_range(0, 1));
            s.wb_wrreg = 5'($urandom_range(0, 7));
            step(s);
        end

        // Reset during drain returns to RUN
        s = '0; step(s);
        s = '0; s.halt = 1'b1;
        step(s);
        s = '0; s.wb = 2'b10;
        step(s);
        do_reset();
        s = '0; s.wb = 2'b01; s.rs = 5'd2;
        step(s);

        // Halt behind load-use waits, then drains and halts
        s = '0; s.wb = 2'b11; s.mem = 4'b0100; s.rt = 5'd7;
        step(s);
        s = '0; s.halt = 1'b1; s.rs = 5'd7;
        step(s);
        step(s);
        s = '0; s.wb = 2'b11; s.mem = 4'b0100; s.a = 32'h77; s.rs = 5'd1;
        for (int i = 0; i < int'(DRAIN); i++) step(s);
        check_eq("halted_after_drain", 64'(halted), 64'd1);
        step(s);
        step(s);
        check_eq("halted_stall_held", 64'(pipe_stall), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
